// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a STAGES-deep valid/ready register pipeline.
// Latency: an item accepted at edge N is visible on out_valid after edge N+STAGES-1.
// Backpressure: each stage stalls while valid and not ready; out_ready reopens in_ready combinationally.
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   flush                 synchronous discard of all in-flight items (in_ready forced low)
//   in_valid/in_ready     input handshake; in_data + mode carry the raw immediate and extension mode
//   out_valid/out_ready   output handshake; out_data is the extended immediate from the last stage
//   occupancy             number of valid stages, registered alongside the valid bits
module imm_extend_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [2:0]       occupancy
);

    localparam int EXT_W = OUT_W - IN_W;

    // Extension: 0 sign, 1 zero, 2 upper-placed, 3 branch (sign-extended, x4).
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_d;

    always_comb begin
        sext  = {{EXT_W{in_data[IN_W-1]}}, in_data};
        ext_d = sext;
        case (mode)
            2'd0:    ext_d = sext;
            2'd1:    ext_d = {{EXT_W{1'b0}}, in_data};
            2'd2:    ext_d = {in_data, {EXT_W{1'b0}}};
            default: ext_d = sext << 2;
        endcase
    end

    // Pipeline state.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [OUT_W-1:0]  data_q [STAGES];
    logic [OUT_W-1:0]  data_d [STAGES];
    logic [2:0]        occ_q;
    logic [2:0]        occ_d;

    // Ready ripples backwards from the consumer: a stage can load if it is
    // empty or everything downstream of it can move.
    logic [STAGES-1:0] rdy;
    logic              rdy_acc;

    always_comb begin
        rdy     = '0;
        rdy_acc = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy_acc = rdy_acc | ~v_q[i];
            rdy[i]  = rdy_acc;
        end
    end

    logic in_fire;
    assign in_ready = rdy[0] & ~flush;
    assign in_fire  = in_valid & in_ready;

    // Upstream source of each stage: the extender for stage 0, otherwise the previous stage.
    logic [STAGES-1:0] up_v;
    logic [OUT_W-1:0]  up_d [STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_up
        if (g == 0) begin : g_first
            assign up_v[g] = in_fire;
            assign up_d[g] = ext_d;
        end else begin : g_next
            assign up_v[g] = v_q[g-1];
            assign up_d[g] = data_q[g-1];
        end
    end

    function automatic logic [2:0] popcnt(input logic [STAGES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < STAGES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Data only moves when a valid item moves in, so a drained pipe keeps
    // its last word; flush clears valids and leaves data stale.
    always_comb begin
        v_d = v_q;
        for (int i = 0; i < STAGES; i++) begin
            data_d[i] = data_q[i];
        end
        if (flush) begin
            v_d = '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v_d[i] = up_v[i];
                    if (up_v[i]) begin
                        data_d[i] = up_d[i];
                    end
                end
            end
        end
        occ_d = popcnt(v_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  occupancy;

    int checks;
    int errors;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m);
        in_valid = v;
        in_data  = d;
        mode     = m;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{16'h03d2, 2'd0, 32'h000003d2};
        vecs[1]  = '{16'hfacc, 2'd0, 32'hfffffacc};
        vecs[2]  = '{16'hfacc, 2'd1, 32'h0000facc};
        vecs[3]  = '{16'h1234, 2'd2, 32'h12340000};
        vecs[4]  = '{16'hfffe, 2'd3, 32'hfffffff8};
        vecs[5]  = '{16'h4000, 2'd3, 32'h00010000};
        vecs[6]  = '{16'h8000, 2'd1, 32'h00008000};
        vecs[7]  = '{16'h8000, 2'd3, 32'hfffe0000};
        vecs[8]  = '{16'h0001, 2'd2, 32'h00010000};
        vecs[9]  = '{16'hffff, 2'd2, 32'hffff0000};
        vecs[10] = '{16'h7fff, 2'd0, 32'h00007fff};
        vecs[11] = '{16'h0000, 2'd3, 32'h00000000};
        vecs[12] = '{16'hc000, 2'd3, 32'hffff0000};
        vecs[13] = '{16'h2000, 2'd3, 32'h00008000};

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 2'd0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_occupancy", {29'b0, occupancy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back table stream: item c driven in iteration c shows up at iteration c+2.
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (c < 14) drive(1'b1, vecs[c].d, vecs[c].m);
            else        drive(1'b0, 16'h0, 2'd0);
            @(negedge clk);
            chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
            chk("stream_occ_le2", {31'b0, (occupancy <= 3'd2)}, 32'd1);
            if (c < 2) begin
                chk("stream_lat_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                chk($sformatf("stream_vld_%0d", c - 2), {31'b0, out_valid}, 32'd1);
                chk($sformatf("stream_dat_%0d", c - 2), out_data, vecs[c-2].exp);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_occ", {29'b0, occupancy}, 32'd0);

        // Backpressure: two items fill the pipe, the third waits until out_ready returns.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(1'b1, 16'h0011, 2'd0);
        @(negedge clk);
        chk("bp_rdy_a", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        drive(1'b1, 16'h8001, 2'd1);
        @(negedge clk);
        chk("bp_rdy_b", {31'b0, in_ready}, 32'd1);
        chk("bp_occ_1", {29'b0, occupancy}, 32'd1);
        @(posedge clk); #1;
        drive(1'b1, 16'h0003, 2'd2);
        @(negedge clk);
        chk("bp_full_rdy", {31'b0, in_ready}, 32'd0);
        chk("bp_full_occ", {29'b0, occupancy}, 32'd2);
        chk("bp_full_vld", {31'b0, out_valid}, 32'd1);
        chk("bp_full_dat", out_data, 32'h00000011);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_stall_dat", out_data, 32'h00000011);
        chk("bp_stall_rdy", {31'b0, in_ready}, 32'd0);
        chk("bp_stall_occ", {29'b0, occupancy}, 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        chk("bp_reopen_rdy", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 16'h0, 2'd0);
        @(negedge clk);
        chk("bp_out_b", out_data, 32'h00008001);
        chk("bp_occ_after", {29'b0, occupancy}, 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_out_c_vld", {31'b0, out_valid}, 32'd1);
        chk("bp_out_c", out_data, 32'h00030000);
        chk("bp_occ_c", {29'b0, occupancy}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_empty_vld", {31'b0, out_valid}, 32'd0);
        chk("bp_empty_occ", {29'b0, occupancy}, 32'd0);

        // Flush with a full pipe and an item offered; out_ready high so only flush blocks it.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(1'b1, 16'h0005, 2'd0);
        @(posedge clk); #1;
        drive(1'b1, 16'h0006, 2'd0);
        @(posedge clk); #1;
        drive(1'b1, 16'h0007, 2'd0);
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        chk("fl_pre_occ", {29'b0, occupancy}, 32'd2);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        drive(1'b0, 16'h0, 2'd0);
        @(negedge clk);
        chk("fl_occ", {29'b0, occupancy}, 32'd0);
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fl_not_accepted_occ", {29'b0, occupancy}, 32'd0);
        chk("fl_not_accepted_vld", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset mid-cycle with two items in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(1'b1, 16'h0009, 2'd0);
        @(posedge clk); #1;
        drive(1'b1, 16'h000a, 2'd0);
        @(posedge clk); #1;
        drive(1'b1, 16'h000b, 2'd0);
        @(negedge clk);
        chk("rs_pre_occ", {29'b0, occupancy}, 32'd2);
        chk("rs_pre_dat", out_data, 32'h00000009);
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rs_async_vld", {31'b0, out_valid}, 32'd0);
        chk("rs_async_dat", out_data, 32'd0);
        chk("rs_async_occ", {29'b0, occupancy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 16'h0, 2'd0);
        @(negedge clk);
        chk("rs_ignored_occ", {29'b0, occupancy}, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 16'h8000, 2'd0);
        @(negedge clk);
        chk("rs_post_rdy", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 16'h0, 2'd0);
        @(negedge clk);
        chk("rs_post_lat_vld", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rs_post_vld", {31'b0, out_valid}, 32'd1);
        chk("rs_post_dat", out_data, 32'hffff8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; legal range 1..OUT_W-2.
REQ-002 Parameter OUT_W, default 32, extended output width.
REQ-003 Parameter STAGES, default 2, pipeline depth; legal range 1..4.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset; asynchronous, active-high.
REQ-006 Port flush  in  1  synchronous discard of all in-flight items.
REQ-007 Port in_valid  in  1  input item present.
REQ-008 Port in_ready  out  1  block can accept the input item this cycle.
REQ-009 Port in_data  in  IN_W  raw immediate field.
REQ-010 Port mode  in  2  extension mode, sampled together with in_data.
REQ-011 Port out_valid  out  1  output item present.
REQ-012 Port out_ready  in  1  consumer accepts the output item.
REQ-013 Port out_data  out  OUT_W  extended immediate.
REQ-014 Port occupancy  out  3  number of valid stages, 0..STAGES.

Function
REQ-015 Transfer rule: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 Extension is computed combinationally from in_data/mode and captured into stage 0; later stages copy without modification.
REQ-017 mode 0, sign: bits [IN_W-1:0] = in_data; upper bits = in_data[IN_W-1].
REQ-018 mode 1, zero: bits [IN_W-1:0] = in_data; upper bits = 0.
REQ-019 mode 2, upper: bits [OUT_W-1:OUT_W-IN_W] = in_data; lower bits = 0.
REQ-020 mode 3, branch: sign-extend per mode 0, then shift left by 2, truncated to OUT_W (top 2 bits lost).
REQ-021 Each stage i holds a valid bit v[i] and a data word; out_valid = v[STAGES-1]; out_data = data of last stage.
REQ-022 Stage readiness: rdy[STAGES-1] = out_ready || !v[STAGES-1]; rdy[i] = rdy[i+1] || !v[i]; in_ready = rdy[0] && !flush.
REQ-023 Stage i loads from stage i-1 (or from input for i=0) when rdy[i]; v[i] takes the upstream valid (stage 0: in_valid && in_ready).
REQ-024 A stage that is valid and not ready holds data and valid unchanged (stall); out_data stays stable while out_valid && !out_ready.
REQ-025 Latency: an item accepted at edge N appears on out_valid after edge N+STAGES-1 when no stall occurs; throughput is 1 item/cycle with out_ready held high.
REQ-026 Items leave in acceptance order; no item is dropped or duplicated except by flush or rst.
REQ-027 flush: at the next edge all v[i] clear; in_ready is 0 during the flush cycle, so any input presented then is not accepted; data registers may keep stale values.
REQ-028 flush together with out_ready: the item on the output is not counted as transferred.
REQ-029 occupancy equals the count of set v[i], updated with the same edge as the valid bits.
REQ-030 Full: all v[i] set and out_ready low -> in_ready 0; asserting out_ready reopens in_ready in the same cycle (combinational path).

Reset
REQ-031 rst asserted clears all v[i], all data registers to 0, out_valid 0, out_data 0, occupancy 0, immediately and independent of clk.
REQ-032 rst asserted mid-stream discards all in-flight items; after release the first accepted item follows REQ-025 latency exactly.
REQ-033 in_ready may be 1 during reset; any transfer presented while rst is high is ignored.

Verification
REQ-034 Defaults, out_ready=1: in_data 16'h03d2 mode 0 -> out_data 32'h000003d2, one cycle after acceptance; then 16'hfacc mode 0 -> 32'hfffffacc.
REQ-035 16'hfacc mode 1 -> 32'h0000facc; 16'h1234 mode 2 -> 32'h12340000; 16'hfffe mode 3 -> 32'hfffffff8; 16'h4000 mode 3 -> 32'h00010000.
REQ-036 Back-to-back: 4 items, one per cycle, out_ready=1 -> 4 consecutive out_valid cycles in order, occupancy never exceeds 2.
REQ-037 Backpressure: out_ready=0, 3 items offered -> 2 accepted, in_ready 0, occupancy 2, out_data stable; out_ready=1 -> third accepted the same cycle, order preserved.
REQ-038 Flush with occupancy 2 and in_valid=1 -> next cycle occupancy 0, out_valid 0, offered item not accepted.
REQ-039 rst asserted between edges with 2 items in flight -> out_valid and out_data 0 before the next edge; post-release item 16'h8000 mode 0 -> 32'hffff8000.
